// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder: FSM state encoding,
// RV-style funct3 load/store size codes and the default wait-state count.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int DEFAULT_WAIT_STATES = 2;

endpackage

// File: rtl/mem_responder_lane_align.sv
// lane_align: combinational byte-lane helper for the memory responder.
// Ports:
//   addr_lo    in   low two byte-address bits (lane select)
//   funct3     in   access size / sign code
//   is_rd      in   access is a load
//   is_wr      in   access is a store
//   wd         in   right-aligned store data
//   rword      in   storage word currently addressed
//   be         out  store byte enables
//   wd_rep     out  store data replicated across the lanes
//   load_data  out  extracted and extended load value
//   fault      out  misalignment, illegal funct3, or load+store together
// Lane arithmetic assumes a 32-bit word (four byte lanes).
module lane_align
  import mem_resp_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]              addr_lo,
  input  logic [2:0]              funct3,
  input  logic                    is_rd,
  input  logic                    is_wr,
  input  logic [DATA_WIDTH-1:0]   wd,
  input  logic [DATA_WIDTH-1:0]   rword,
  output logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   wd_rep,
  output logic [DATA_WIDTH-1:0]   load_data,
  output logic                    fault
);

  localparam int NB = DATA_WIDTH / 8;

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        acc_half;
  logic        acc_word;
  logic        bad_f3;

  always_comb begin
    byte_v    = rword[{addr_lo, 3'b000} +: 8];
    half_v    = rword[{addr_lo[1], 4'b0000} +: 16];
    acc_half  = (funct3[1:0] == 2'b01);
    acc_word  = (funct3[1:0] == 2'b10);
    be        = '0;
    wd_rep    = wd;
    load_data = '0;

    // Loads accept 000/001/010/100/101, stores only 000/001/010.
    if (is_wr) bad_f3 = (funct3 > 3'd2);
    else       bad_f3 = (funct3 == 3'd3) || (funct3[2:1] == 2'b11);

    fault = (is_rd & is_wr) | bad_f3 | (acc_half & addr_lo[0]) |
            (acc_word & (addr_lo != 2'b00));

    case (funct3)
      F3_SB: begin
        be[addr_lo] = 1'b1;
        wd_rep      = {NB{wd[7:0]}};
      end
      F3_SH: begin
        be[{addr_lo[1], 1'b0} +: 2] = 2'b11;
        wd_rep                      = {(NB/2){wd[15:0]}};
      end
      F3_SW:   be = '1;
      default: be = '0;
    endcase

    case (funct3)
      F3_LB:   load_data = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
      F3_LH:   load_data = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
      F3_LW:   load_data = rword;
      F3_LBU:  load_data = {{(DATA_WIDTH-8){1'b0}}, byte_v};
      F3_LHU:  load_data = {{(DATA_WIDTH-16){1'b0}}, half_v};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: word-organised data memory with a fixed number of wait
// states per access, byte/half/word loads and stores, and fault reporting.
// Ports:
//   clk_i        in   clock, rising edge
//   reset_i      in   asynchronous active-low reset
//   byte_addr_i  in   byte address (wraps modulo 4*DEPTH_WORDS)
//   wd_i         in   store data, right-aligned
//   funct3_i     in   access size / sign code
//   mrd_i        in   read request
//   mwr_i        in   write request
//   rd_o         out  registered load data
//   busy_o       out  access in progress (wait states)
//   mem_rdy_o    out  one-cycle completion pulse
//   fault_o      out  one-cycle error pulse with mem_rdy_o
//
// state      | meaning
// ST_IDLE    | ready; a request is captured on the next rising edge
// ST_WAIT    | counting down wait states, busy_o high
// ST_RESPOND | completion cycle, mem_rdy_o (and fault_o) high
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [31:0]           byte_addr_i,
  input  logic [DATA_WIDTH-1:0] wd_i,
  input  logic [2:0]            funct3_i,
  input  logic                  mrd_i,
  input  logic                  mwr_i,
  output logic [DATA_WIDTH-1:0] rd_o,
  output logic                  busy_o,
  output logic                  mem_rdy_o,
  output logic                  fault_o
);

  localparam int         IDX_W   = $clog2(DEPTH_WORDS);
  localparam int         NB      = DATA_WIDTH / 8;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W+1:0]      addr_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic [2:0]            f3_q;
  logic                  mrd_q, mwr_q;

  logic                  accept;
  logic                  enter_resp;
  logic [IDX_W+1:0]      op_addr;
  logic [DATA_WIDTH-1:0] op_wd;
  logic [2:0]            op_f3;
  logic                  op_rd, op_wr;
  logic [IDX_W-1:0]      idx;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] rword;
  logic [DATA_WIDTH-1:0] wd_rep;
  logic [DATA_WIDTH-1:0] load_data;
  logic [NB-1:0]         be;
  logic                  fault;
  logic                  unused_addr;

  assign unused_addr = ^byte_addr_i[31:IDX_W+2];
  assign accept      = (state_q == ST_IDLE) && (mrd_i || mwr_i);

  // With zero wait states the access completes on the acceptance edge
  // itself, so in IDLE the live inputs stand in for the captured request.
  always_comb begin
    if (state_q == ST_IDLE) begin
      op_addr = byte_addr_i[IDX_W+1:0];
      op_wd   = wd_i;
      op_f3   = funct3_i;
      op_rd   = mrd_i;
      op_wr   = mwr_i;
    end else begin
      op_addr = addr_q;
      op_wd   = wd_q;
      op_f3   = f3_q;
      op_rd   = mrd_q;
      op_wr   = mwr_q;
    end
  end

  assign idx   = op_addr[IDX_W+1:2];
  assign rword = mem[idx];

  lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_align (
    .addr_lo   (op_addr[1:0]),
    .funct3    (op_f3),
    .is_rd     (op_rd),
    .is_wr     (op_wr),
    .wd        (op_wd),
    .rword     (rword),
    .be        (be),
    .wd_rep    (wd_rep),
    .load_data (load_data),
    .fault     (fault)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = ST_RESPOND;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESPOND;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign enter_resp = (state_d == ST_RESPOND) && (state_q != ST_RESPOND);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      f3_q    <= '0;
      mrd_q   <= 1'b0;
      mwr_q   <= 1'b0;
      rd_o    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q <= byte_addr_i[IDX_W+1:0];
        wd_q   <= wd_i;
        f3_q   <= funct3_i;
        mrd_q  <= mrd_i;
        mwr_q  <= mwr_i;
      end
      if (enter_resp)
        rd_o <= (op_rd && !op_wr && !fault) ? load_data : '0;
    end
  end

  // Storage is never reset; the reset_i gate keeps a request presented
  // while reset is held from committing a store.
  always_ff @(posedge clk_i) begin
    if (reset_i && enter_resp && op_wr && !fault) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd_rep[8*i +: 8];
      end
    end
  end

  assign busy_o    = (state_q == ST_WAIT);
  assign mem_rdy_o = (state_q == ST_RESPOND);
  assign fault_o   = (state_q == ST_RESPOND) && fault;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] addr_a, wd_a, addr_b, wd_b;
  logic [2:0]  f3_a, f3_b;
  logic        mrd_a, mwr_a, mrd_b, mwr_b;
  logic [31:0] rd_a, rd_b;
  logic        busy_a, rdy_a, flt_a, busy_b, rdy_b, flt_b;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem_m [2][1024];

  mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_STATES(2)) dut_a (
    .clk_i(clk), .reset_i(rst_n), .byte_addr_i(addr_a), .wd_i(wd_a),
    .funct3_i(f3_a), .mrd_i(mrd_a), .mwr_i(mwr_a), .rd_o(rd_a),
    .busy_o(busy_a), .mem_rdy_o(rdy_a), .fault_o(flt_a));

  mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) dut_b (
    .clk_i(clk), .reset_i(rst_n), .byte_addr_i(addr_b), .wd_i(wd_b),
    .funct3_i(f3_b), .mrd_i(mrd_b), .mwr_i(mwr_b), .rd_o(rd_b),
    .busy_o(busy_b), .mem_rdy_o(rdy_b), .fault_o(flt_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, input logic r, input logic w);
    if (sel == 0) begin
      addr_a = a; wd_a = wd; f3_a = f3; mrd_a = r; mwr_a = w;
    end else begin
      addr_b = a; wd_b = wd; f3_b = f3; mrd_b = r; mwr_b = w;
    end
  endtask

  // Reference: byte-wise memory image with RISC-V load/store rules.
  function automatic void model(input int sel, input logic [31:0] a, input logic [31:0] wd,
                                input logic [2:0] f3, input logic r, input logic w,
                                output logic flt, output logic [31:0] rdv);
    int idx, ln, size;
    logic [31:0] word, mask;
    logic ok;
    idx  = int'((a >> 2) % 1024);
    ln   = int'(a % 4);
    word = mem_m[sel][idx];
    if (w) size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    else   size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (w) ok = (f3 <= 3'd2);
    else   ok = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
    if (ln % size != 0) ok = 1'b0;
    if (r && w) ok = 1'b0;
    flt = !ok;
    rdv = '0;
    if (ok && w) begin
      for (int k = 0; k < size; k++) word[8*(ln+k) +: 8] = wd[8*k +: 8];
      mem_m[sel][idx] = word;
    end else if (ok && r) begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
      rdv  = (word >> (8*ln)) & mask;
      if (f3 < 3'd4 && size < 4 && rdv[8*size-1]) rdv = rdv | ~mask;
    end
  endfunction

  task automatic access(input int sel, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input logic r, input logic w, input string tag);
    logic        exp_f;
    logic [31:0] exp_rd;
    int          ws;
    ws = (sel == 0) ? 2 : 0;
    @(negedge clk);
    drive(sel, a, wd, f3, r, w);
    @(posedge clk);
    #1 drive(sel, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'b0, 1'b0);
    model(sel, a, wd, f3, r, w, exp_f, exp_rd);
    for (int c = 1; c <= ws + 1; c++) begin
      @(negedge clk);
      check({tag, "/busy"}, {31'b0, (sel == 0) ? busy_a : busy_b}, {31'b0, c <= ws});
      check({tag, "/rdy"},  {31'b0, (sel == 0) ? rdy_a : rdy_b},   {31'b0, c == ws + 1});
      if (c == ws + 1) begin
        check({tag, "/fault"}, {31'b0, (sel == 0) ? flt_a : flt_b}, {31'b0, exp_f});
        check({tag, "/rd"},    (sel == 0) ? rd_a : rd_b,            exp_rd);
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    int          op;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 1'b0, 1'b0);
    drive(1, 0, 0, 0, 1'b0, 1'b0);
    #12;
    check("rst/busy_a", {31'b0, busy_a}, 0);
    check("rst/rdy_a",  {31'b0, rdy_a},  0);
    check("rst/flt_a",  {31'b0, flt_a},  0);
    check("rst/rd_a",   rd_a,            0);
    check("rst/busy_b", {31'b0, busy_b}, 0);
    check("rst/rd_b",   rd_b,            0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // word store then load, two wait states
    access(0, 32'h10, 32'hDEAD_BEEF, 3'b010, 1'b0, 1'b1, "sw10");
    access(0, 32'h10, 32'h0,         3'b010, 1'b1, 1'b0, "lw10");

    // byte lane merge and extension
    access(0, 32'h10, 32'h1122_3344, 3'b010, 1'b0, 1'b1, "sw10b");
    access(0, 32'h13, 32'h0000_0080, 3'b000, 1'b0, 1'b1, "sb13");
    access(0, 32'h13, 32'h0,         3'b000, 1'b1, 1'b0, "lb13");
    access(0, 32'h13, 32'h0,         3'b100, 1'b1, 1'b0, "lbu13");
    access(0, 32'h10, 32'h0,         3'b010, 1'b1, 1'b0, "lw10b");

    // misalignment faults leave memory unchanged
    access(0, 32'h11, 32'h0,         3'b001, 1'b1, 1'b0, "lh11");
    access(0, 32'h12, 32'hFFFF_FFFF, 3'b010, 1'b0, 1'b1, "sw12");
    access(0, 32'h10, 32'h0,         3'b010, 1'b1, 1'b0, "lw10c");

    // read+write together and undefined load code
    access(0, 32'h10, 32'h0BAD_0BAD, 3'b010, 1'b1, 1'b1, "rdwr");
    access(0, 32'h10, 32'h0,         3'b011, 1'b1, 1'b0, "ld011");
    access(0, 32'h10, 32'h0,         3'b010, 1'b1, 1'b0, "lw10d");

    // reset mid-WAIT discards the store
    access(0, 32'h20, 32'h55AA_55AA, 3'b010, 1'b0, 1'b1, "sw20");
    access(0, 32'h10, 32'h0,         3'b010, 1'b1, 1'b0, "lw10e");
    @(negedge clk);
    drive(0, 32'h20, 32'hCAFE_F00D, 3'b010, 1'b0, 1'b1);
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    check("midrst/busy_pre", {31'b0, busy_a}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst/busy", {31'b0, busy_a}, 0);
    check("midrst/rdy",  {31'b0, rdy_a},  0);
    check("midrst/flt",  {31'b0, flt_a},  0);
    check("midrst/rd",   rd_a,            0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    access(0, 32'h20, 32'h0, 3'b010, 1'b1, 1'b0, "lw20");

    // zero wait states and address aliasing
    access(1, 32'h1010, 32'h0BAD_F00D, 3'b010, 1'b0, 1'b1, "ws0/sw1010");
    access(1, 32'h0010, 32'h0,         3'b010, 1'b1, 1'b0, "ws0/lw10");
    access(1, 32'h0012, 32'h0,         3'b101, 1'b1, 1'b0, "ws0/lhu12");
    access(1, 32'h0011, 32'h0,         3'b001, 1'b1, 1'b0, "ws0/lh11");

    // randomized traffic over 64 words with aliasing upper bits
    for (int i = 0; i < 64; i++)
      access(0, 32'(i * 4), $urandom, 3'b010, 1'b0, 1'b1, "init");
    for (int i = 0; i < 80; i++) begin
      a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
      op = $urandom_range(0, 9);
      access(i % 4 == 3 ? 1 : 0, a, $urandom, 3'($urandom_range(0, 7)),
             (op < 5) || (op == 9), op >= 5, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data bus width.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024: storage depth in words, a power of 2.
REQ-003 SHALL have parameter WAIT_STATES, default 2: busy cycles inserted per access, range 0..15.
REQ-004 SHALL have the following ports, clock and reset first:
  clk_i  in  1  sole clock, rising edge.
  reset_i  in  1  asynchronous, active-low reset.
  byte_addr_i  in  32  byte address.
  wd_i  in  DATA_WIDTH  store data, right-aligned.
  funct3_i  in  3  access size and sign encoding.
  mrd_i  in  1  read request.
  mwr_i  in  1  write request.
  rd_o  out  DATA_WIDTH  load data, extended.
  busy_o  out  1  access in progress; feeds the control matrix mem_busy input.
  mem_rdy_o  out  1  one-cycle completion pulse.
  fault_o  out  1  one-cycle error pulse, coincident with mem_rdy_o.

Function
REQ-005 SHALL implement FSM states IDLE, WAIT and RESPOND.
REQ-006 SHALL, in IDLE, accept a request on the rising edge where mrd_i|mwr_i=1 and register byte_addr_i, wd_i, funct3_i, mrd_i and mwr_i.
REQ-007 SHALL, on acceptance, go to WAIT and load the wait counter with WAIT_STATES-1 when WAIT_STATES>0, or go directly to RESPOND when WAIT_STATES=0.
REQ-008 SHALL, in WAIT, decrement the counter each cycle and go to RESPOND on the edge where the counter equals 0.
REQ-009 SHALL drive busy_o=1 in WAIT only; busy_o SHALL go high the cycle after acceptance for exactly WAIT_STATES cycles.
REQ-010 SHALL drive mem_rdy_o=1 for exactly one cycle in RESPOND, then return to IDLE; total latency is WAIT_STATES+1 cycles from acceptance edge to mem_rdy_o.
REQ-011 SHALL treat request inputs in the cycle after RESPOND (in IDLE) as a new request; the requester SHALL deassert mrd_i/mwr_i in the mem_rdy_o cycle. Inputs during WAIT/RESPOND SHALL be ignored.
REQ-012 SHALL form the word index as captured addr[log2(DEPTH_WORDS)+1:2]; higher bits SHALL be ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-013 SHALL decode loads as: 000 LB sign-extend; 001 LH sign-extend; 010 LW; 100 LBU zero-extend; 101 LHU zero-extend. Lane is selected by addr[1:0].
REQ-014 SHALL decode stores as: 000 SB byte lane addr[1:0]; 001 SH half lane addr[1]; 010 SW. Unselected bytes SHALL be preserved.
REQ-015 SHALL commit a store on the edge entering RESPOND.
REQ-016 SHALL raise a fault on any of: a misaligned half (addr[0]=1); a misaligned word (addr[1:0]!=0); an undefined funct3 (loads 011/110/111, stores 011..111); or mrd and mwr captured simultaneously.
REQ-017 SHALL, on a fault, suppress the write, force rd_o=0 and pulse fault_o with mem_rdy_o; latency SHALL be unchanged.
REQ-018 SHALL hold rd_o registered and valid in RESPOND, holding its last value otherwise; rd_o SHALL be 0 after a write.

Reset
REQ-019 SHALL, while reset_i=0, immediately force state=IDLE, counter=0, busy_o=0, mem_rdy_o=0, fault_o=0, rd_o=0 and clear the captured request.
REQ-020 SHALL discard an in-flight access on reset mid-WAIT with no write committed; storage contents SHALL NOT be reset.
REQ-021 SHALL accept the first request on the first rising edge after reset_i returns high.

Structure
REQ-022 SHALL place the state enum, funct3 load/store constants and the default WAIT_STATES in shared package mem_resp_pkg.
REQ-023 SHALL use one sub-module, lane_align (combinational): store byte-enable and data-replication generator plus load extract/extend and misalignment detect.
REQ-024 SHALL use inferred single-port synchronous-write storage with no vendor primitives.

Verification
REQ-025 SHALL cover: SW 0xDEADBEEF @0x10, then LW @0x10 (WAIT_STATES=2) -> busy_o high 2 cycles, mem_rdy_o on cycle 3, rd_o=0xDEADBEEF.
REQ-026 SHALL cover: SB 0x80 @0x13 over word 0x11223344, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80223344.
REQ-027 SHALL cover: LH @0x11 -> fault_o=1, rd_o=0, memory unchanged; SW @0x12 -> fault_o=1, no write.
REQ-028 SHALL cover: mrd_i=mwr_i=1 -> fault_o=1; funct3=011 load -> fault_o=1.
REQ-029 SHALL cover: reset_i low during WAIT of SW 0xCAFEF00D @0x20 -> outputs 0 immediately; a subsequent LW @0x20 returns the old value.
REQ-030 SHALL cover: WAIT_STATES=0 -> busy_o never high, mem_rdy_o the cycle after acceptance; address 0x1010 with DEPTH_WORDS=1024 aliases 0x0010.
